// File: rtl/branch_pc_unit.sv
// Branch resolution and architectural PC register with redirect, misaligned-target trap and flush sequencing.
// Optional build macro BRANCH_STATS_EN adds saturating branch statistics outputs BrTotal/BrTaken.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [2:0]  Funct3,
    input  logic        BrLT,
    input  logic        BrEq,
    input  logic [31:0] Target,
    output logic        BrUn,
    output logic        PCSel,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        Flush,
    output logic        Trap
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] BrTotal,
    output logic [31:0] BrTaken
`endif
);

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        trap_q, trap_d;

    logic        cond;
    logic        take;
    logic        misalign;
    logic [31:0] eff_target;
    logic [31:0] pc4;

    always_comb begin
        cond = 1'b0;
        unique case (Funct3)
            3'b000:          cond = BrEq;
            3'b001:          cond = ~BrEq;
            3'b100, 3'b110:  cond = BrLT;
            3'b101, 3'b111:  cond = ~BrLT;
            default:         cond = 1'b0;
        endcase
    end

    assign BrUn       = Funct3[1];
    assign take       = Jump | (Branch & cond);
    // Squashed instructions seen while flushing must never redirect.
    assign PCSel      = take & (state_q == ST_RUN) & ~Stall;
    assign eff_target = Target & ~32'h0000_0001;
    assign misalign   = Target[1];
    assign pc4        = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        trap_d  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!Stall) begin
                    if (PCSel) begin
                        pc_d    = misalign ? TRAP_VEC : eff_target;
                        trap_d  = misalign;
                        cnt_d   = FLUSH_INIT;
                        state_d = ST_FLUSH;
                        flush_d = 1'b1;
                    end else begin
                        pc_d = pc4;
                    end
                end
            end
            ST_FLUSH: begin
                if (!Stall) begin
                    pc_d = pc4;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_RUN;
                        flush_d = 1'b0;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                flush_d = 1'b0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            trap_q  <= trap_d;
        end
    end

    assign PC    = pc_q;
    assign PC4   = pc4;
    assign Flush = flush_q;
    assign Trap  = trap_q;

`ifdef BRANCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] total_q, total_d;
    logic [31:0] taken_q, taken_d;
    logic        counted;

    assign counted = (state_q == ST_RUN) & ~Stall & Branch;

    always_comb begin
        total_d = total_q;
        taken_d = taken_q;
        if (counted) begin
            total_d = sat_inc(total_q);
            if (cond) begin
                taken_d = sat_inc(taken_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= 32'd0;
            taken_q <= 32'd0;
        end else begin
            total_q <= total_d;
            taken_q <= taken_d;
        end
    end

    assign BrTotal = total_q;
    assign BrTaken = taken_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed cycle-by-cycle bench for branch_pc_unit: vector table plus an async-reset-during-flush sequence.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        Stall, Branch, Jump;
    logic [2:0]  Funct3;
    logic        BrLT, BrEq;
    logic [31:0] Target;
    logic        BrUn, PCSel;
    logic [31:0] PC, PC4;
    logic        Flush, Trap;
`ifdef BRANCH_STATS_EN
    logic [31:0] BrTotal, BrTaken;
`endif

    branch_pc_unit #(
        .RESET_PC     (32'h0000_0000),
        .TRAP_VEC     (32'h0000_0100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Stall  (Stall),
        .Branch (Branch),
        .Jump   (Jump),
        .Funct3 (Funct3),
        .BrLT   (BrLT),
        .BrEq   (BrEq),
        .Target (Target),
        .BrUn   (BrUn),
        .PCSel  (PCSel),
        .PC     (PC),
        .PC4    (PC4),
        .Flush  (Flush),
        .Trap   (Trap)
`ifdef BRANCH_STATS_EN
        ,
        .BrTotal(BrTotal),
        .BrTaken(BrTaken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st, br, jp;
        logic [2:0]  f3;
        logic        lt, eq;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        pcsel, brun, flush, trap;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs[NV];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic st, br, jp, input logic [2:0] f3,
                                input logic lt, eq, input logic [31:0] tgt,
                                input logic [31:0] pc, input logic pcsel, brun, flush, trap);
        vec_t v;
        v.st = st; v.br = br; v.jp = jp; v.f3 = f3; v.lt = lt; v.eq = eq; v.tgt = tgt;
        v.pc = pc; v.pcsel = pcsel; v.brun = brun; v.flush = flush; v.trap = trap;
        return v;
    endfunction

    function automatic vec_t idle(input logic [31:0] pc, input logic flush, trap);
        return mk(0, 0, 0, 3'b000, 0, 0, 32'h0, pc, 0, 0, flush, trap);
    endfunction

    function automatic logic cond_of(input logic [2:0] f, input logic lt, eq);
        case (f)
            3'b000: return eq;
            3'b001: return !eq;
            3'b100, 3'b110: return lt;
            3'b101, 3'b111: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Stall = v.st; Branch = v.br; Jump = v.jp; Funct3 = v.f3;
        BrLT = v.lt; BrEq = v.eq; Target = v.tgt;
    endtask

    initial begin
        int exp_total = 0;
        int exp_taken = 0;

        vecs[0]  = idle(32'h00, 0, 0);
        vecs[1]  = idle(32'h04, 0, 0);
        vecs[2]  = idle(32'h08, 0, 0);
        vecs[3]  = idle(32'h0C, 0, 0);
        vecs[4]  = mk(0, 1, 0, 3'b000, 0, 1, 32'h40,   32'h10, 1, 0, 0, 0);
        vecs[5]  = idle(32'h40, 1, 0);
        vecs[6]  = idle(32'h44, 1, 0);
        vecs[7]  = mk(0, 1, 0, 3'b111, 1, 0, 32'h90,   32'h48, 0, 1, 0, 0);
        vecs[8]  = mk(0, 1, 0, 3'b101, 0, 0, 32'h80,   32'h4C, 1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 3'b000, 0, 1, 32'h200,  32'h80, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 1, 3'b000, 0, 0, 32'h300,  32'h84, 0, 0, 1, 0);
        vecs[11] = mk(0, 0, 1, 3'b010, 0, 0, 32'h1002, 32'h88, 1, 1, 0, 0);
        vecs[12] = idle(32'h100, 1, 1);
        vecs[13] = idle(32'h104, 1, 0);
        vecs[14] = mk(1, 1, 0, 3'b000, 0, 1, 32'h20,   32'h108, 0, 0, 0, 0);
        vecs[15] = mk(0, 1, 0, 3'b000, 0, 1, 32'h20,   32'h108, 1, 0, 0, 0);
        vecs[16] = mk(1, 0, 0, 3'b000, 0, 0, 32'h0,    32'h20, 0, 0, 1, 0);
        vecs[17] = mk(1, 0, 0, 3'b000, 0, 0, 32'h0,    32'h20, 0, 0, 1, 0);
        vecs[18] = idle(32'h20, 1, 0);
        vecs[19] = idle(32'h24, 1, 0);
        vecs[20] = mk(0, 0, 1, 3'b000, 0, 0, 32'h2,    32'h28, 1, 0, 0, 0);
        vecs[21] = mk(1, 0, 0, 3'b000, 0, 0, 32'h0,    32'h100, 0, 0, 1, 1);
        vecs[22] = idle(32'h100, 1, 0);
        vecs[23] = idle(32'h104, 1, 0);
        vecs[24] = mk(0, 1, 0, 3'b100, 1, 0, 32'h5,    32'h108, 1, 0, 0, 0);
        vecs[25] = idle(32'h04, 1, 0);
        vecs[26] = idle(32'h08, 1, 0);
        vecs[27] = mk(0, 1, 0, 3'b001, 0, 1, 32'h50,   32'h0C, 0, 0, 0, 0);
        vecs[28] = mk(0, 1, 0, 3'b001, 0, 0, 32'hFFFF_FFF8, 32'h10, 1, 0, 0, 0);
        vecs[29] = idle(32'hFFFF_FFF8, 1, 0);
        vecs[30] = idle(32'hFFFF_FFFC, 1, 0);
        vecs[31] = mk(0, 1, 0, 3'b011, 1, 1, 32'h60,   32'h00, 0, 1, 0, 0);
        vecs[32] = idle(32'h04, 0, 0);

        rst_n = 1'b0;
        drive(idle(32'h0, 0, 0));
        #3;
        check("reset_pc", PC, 32'h0);
        check("reset_flush", {31'd0, Flush}, 32'd0);
        check("reset_trap", {31'd0, Trap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_pc", i), PC, vecs[i].pc);
            check($sformatf("v%0d_pc4", i), PC4, vecs[i].pc + 32'd4);
            check($sformatf("v%0d_pcsel", i), {31'd0, PCSel}, {31'd0, vecs[i].pcsel});
            check($sformatf("v%0d_brun", i), {31'd0, BrUn}, {31'd0, vecs[i].brun});
            check($sformatf("v%0d_flush", i), {31'd0, Flush}, {31'd0, vecs[i].flush});
            check($sformatf("v%0d_trap", i), {31'd0, Trap}, {31'd0, vecs[i].trap});
            if (!vecs[i].flush && !vecs[i].st && vecs[i].br) begin
                exp_total++;
                if (cond_of(vecs[i].f3, vecs[i].lt, vecs[i].eq)) exp_taken++;
            end
            @(negedge clk);
        end

`ifdef BRANCH_STATS_EN
        check("stats_total", BrTotal, 32'(exp_total));
        check("stats_taken", BrTaken, 32'(exp_taken));
`endif

        // Taken branch, then asynchronous reset in the middle of the flush window.
        check("pre_redirect_pc", PC, 32'h08);
        drive(mk(0, 1, 0, 3'b000, 0, 1, 32'h40, 32'h0, 0, 0, 0, 0));
        #1;
        check("pre_redirect_pcsel", {31'd0, PCSel}, 32'd1);
        @(posedge clk);
        #1;
        drive(idle(32'h0, 0, 0));
        check("mid_flush_pc", PC, 32'h40);
        check("mid_flush_flag", {31'd0, Flush}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", PC, 32'h0);
        check("async_rst_flush", {31'd0, Flush}, 32'd0);
        check("async_rst_trap", {31'd0, Trap}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("async_rst_stats", BrTotal | BrTaken, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_pc0", PC, 32'h0);
        check("post_rst_flush0", {31'd0, Flush}, 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_pc1", PC, 32'h4);
        check("post_rst_flush1", {31'd0, Flush}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Consumes BrLT/BrEq from the branch comparator and drives its BrUn select.
- Resolves branch/jump outcome from Funct3 and owns the architectural PC register.
- On a taken redirect or misaligned target: redirects PC, then asserts a multi-cycle Flush to squash wrong-path fetch/decode.
- Sits between the comparator stage and instruction fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on misaligned taken target
FLUSH_CYCLES, 2, number of non-stalled cycles Flush stays high after a redirect; legal range 1..7

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Stall  in  1  hold PC and FSM; decision not evaluated
Branch  in  1  current instruction is a conditional branch
Jump  in  1  current instruction is JAL/JALR (unconditional)
Funct3  in  3  branch type field
BrLT  in  1  from comparator: A < B (signedness per BrUn)
BrEq  in  1  from comparator: A == B
Target  in  32  computed branch/jump target address
BrUn  out  1  to comparator: 1 = unsigned compare (comb, = Funct3[1])
PCSel  out  1  comb: redirect taken this cycle
PC  out  32  registered current PC
PC4  out  32  comb: PC + 4, wraps modulo 2^32
Flush  out  1  registered: squash younger pipeline stages
Trap  out  1  registered one-cycle pulse: misaligned target

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, state=RUN, flush counter=0, Flush=0, Trap=0. Reset mid-FLUSH aborts the flush immediately.
- Condition decode (comb):
  - 000 BEQ -> BrEq; 001 BNE -> !BrEq
  - 100 BLT / 110 BLTU -> BrLT; 101 BGE / 111 BGEU -> !BrLT
  - 010/011 -> not taken
- take = Jump | (Branch & cond). Jump wins regardless of Funct3.
- PCSel = take & (state==RUN) & !Stall. Forced 0 in FLUSH: squashed instructions never redirect.
- Effective target = {Target[31:1],1'b0}; misalign = Target[1].
- FSM state RUN:
  - Stall=1: PC, state and outputs hold.
  - Stall=0 & PCSel & !misalign: PC<=effective target; counter<=FLUSH_CYCLES; state<=FLUSH; Flush<=1 next edge.
  - Stall=0 & PCSel & misalign: PC<=TRAP_VEC; Trap<=1 for exactly one cycle; same flush entry as above.
  - Stall=0 & !PCSel: PC<=PC4.
- FSM state FLUSH:
  - Flush=1 throughout.
  - Each non-stalled cycle: PC<=PC4 and counter decrements.
  - When counter reaches 1 with Stall=0: state<=RUN and Flush<=0 at that edge.
  - Stall freezes both the counter and PC.
- Latency: redirect visible on PC one edge after the deciding cycle. Flush covers exactly FLUSH_CYCLES non-stalled cycles.
- Wrap-around: PC 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
- Trap is cleared on the next edge even if Stall=1.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds outputs BrTotal[31:0] and BrTaken[31:0].
  - BrTotal counts non-stalled RUN cycles with Branch=1.
  - BrTaken counts those where cond=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 free cycles, no branch -> PC 0x0, 0x4, 0x8, 0xC; Flush=0; Trap=0.
- PC=0x10, Branch=1, Funct3=000, BrEq=1, Target=0x40 -> PCSel=1; next PC=0x40; Flush=1 for 2 cycles (PC 0x40, 0x44); PC 0x48 with Flush=0.
- Funct3=111, BrLT=1 -> BrUn=1, not taken, PC+4. Funct3=101, BrLT=0 -> BrUn=0, taken.
- Jump=1, Target=0x1002 -> PC=TRAP_VEC 0x100; Trap high exactly one cycle; Flush for 2 cycles.
- Taken branch with Stall=1 -> PC holds, PCSel=0. Release Stall next cycle -> redirect then. Stall during FLUSH -> Flush extended by the number of stalled cycles.
- rst_n low mid-FLUSH -> PC=RESET_PC, Flush=0 immediately. In FLUSH, Branch=1 with BrEq=1, Funct3=000 -> PCSel=0, no redirect.
